div36x18: RTL and testbench
===========================

# div36x18

Registered, iterative 36-by-18 divider: the inverse of the team's pipelined 18x18 multiplier. A 36-bit dividend and an 18-bit divisor, each with a per-operand signed flag, are accepted with a valid/ready handshake. The block computes a 36-bit quotient and 18-bit remainder over a fixed number of cycles using restoring radix-2 division, and holds the result until the consumer accepts it. It sits beside the multiplier in the arithmetic datapath and consumes products of that width.

## Interface
- No parameters; all widths are fixed (36/18).
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  operand strobe; accepted when i_valid && o_ready at a rising edge
- o_ready  out  1  block can accept operands (high only in IDLE)
- i_dividend  in  36  dividend
- i_divisor  in  18  divisor
- i_dividend_ns  in  1  1 = dividend is two's-complement signed, 0 = unsigned
- i_divisor_ns  in  1  1 = divisor is two's-complement signed, 0 = unsigned
- o_valid  out  1  result valid; held until i_ready
- i_ready  in  1  consumer accepts result when o_valid && i_ready
- o_quotient  out  36  quotient (signed format if either _ns flag was set, else unsigned)
- o_remainder  out  18  remainder; sign follows dividend
- o_dbz  out  1  divisor was zero
- o_ovf  out  1  quotient not representable in output format

## Operation
- States: IDLE, CALC, FIX, DONE. Reset to IDLE.
- IDLE: o_ready=1. On accept:
  - register operand magnitudes: |x| if flag set and MSB set, else raw;
  - register neg_q = (dividend negative) XOR (divisor negative), neg_r = dividend negative, and signed_out = either flag;
  - clear the 19-bit partial remainder and 6-bit counter;
  - go to CALC.
- CALC: 36 iterations, one per cycle, MSB first:
  - shift {rem, dividend} left 1;
  - trial = rem − divisor (19-bit);
  - if trial ≥ 0, rem = trial and quotient bit = 1; else quotient bit = 0.
  - After the counter reaches 35, go to FIX.
- FIX:
  - o_quotient = neg_q ? −mag_q : mag_q;
  - o_remainder = neg_r ? −mag_r : mag_r.
  - Truncating division: dividend = quotient·divisor + remainder, and |remainder| < |divisor|.
  - Go to DONE.
- Divide by zero: the block still runs the full CALC/FIX sequence (fixed latency). Forced results: o_quotient = 36'hF_FFFF_FFFF, o_remainder = i_dividend[17:0] as captured, o_dbz = 1, o_ovf = 0.
- Overflow:
  - If signed_out, o_ovf=1 when the true quotient lies outside [−2^35, 2^35−1]. Example: −2^35 / −1. The quotient then wraps to its low 36 bits.
  - If unsigned output, overflow is impossible.
- DONE: o_valid=1; outputs stable. On i_ready, go to IDLE and drop o_valid. o_ready is not asserted in the same cycle, so there is no back-to-back accept in the DONE→IDLE cycle.
- i_valid is ignored outside IDLE. Operand inputs may change after acceptance without effect.

## Timing
- Reset value of every output: o_ready=1, o_valid=0, o_quotient=0, o_remainder=0, o_dbz=0, o_ovf=0. Reset is synchronous: effective at the first rising edge with i_rst=1.
- Reset mid-operation (CALC/FIX/DONE) aborts the operation, returns to IDLE with the reset values above, and discards the pending result.
- Latency: accept at edge N → CALC at edges N+1..N+36 → FIX at N+37 → o_valid=1 after edge N+38. Latency is fixed at 38 cycles for all operands, including divide by zero.
- Handshake:
  - o_valid stays high, with outputs constant, for as many cycles as i_ready is low.
  - o_ready rises the cycle after the result is taken.
  - Minimum accept-to-accept spacing is 40 cycles.
- Result outputs (quotient, remainder, flags) keep their last values in IDLE until the next FIX overwrites them.

## Test plan
- Unsigned basic: dividend 36'd1000, divisor 18'd7, both flags 0 → after 38 cycles quotient 142, remainder 6, dbz=0, ovf=0; o_ready low throughout.
- Signed sign rules: −100 / 7 → quotient −14, remainder −2; 100 / −7 → −14, 2; −100 / −7 → 14, −2 (both flags 1).
- Divide by zero: dividend 36'h0_0001_2345, divisor 0 → quotient 36'hF_FFFF_FFFF, remainder 18'h1_2345, dbz=1, latency still 38.
- Signed overflow: dividend 36'h8_0000_0000 (signed), divisor 18'h3_FFFF (−1, signed) → ovf=1, quotient 36'h8_0000_0000, remainder 0.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid → outputs stable and o_ready=0 throughout; pulse i_ready → o_valid=0 next cycle, o_ready=1; a new i_valid in the i_ready cycle is not accepted.
- Reset mid-CALC: assert i_rst at cycle 20 of CALC → next cycle o_ready=1, o_valid=0, all outputs 0; a following 36'd81 / 18'd9 gives 9 rem 0.

Source files
------------

// File: rtl/div36x18.sv
// Iterative 36-by-18 restoring divider with per-operand signedness flags.
// One quotient bit per cycle; the result is held on o_valid until the consumer takes it.
module div36x18 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [35:0] i_dividend,
  input  logic [17:0] i_divisor,
  input  logic        i_dividend_ns,
  input  logic        i_divisor_ns,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [35:0] o_quotient,
  output logic [17:0] o_remainder,
  output logic        o_dbz,
  output logic        o_ovf,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: an operand transfer happens on a rising edge with i_valid && o_ready;
  // a result transfer happens on a rising edge with o_valid && i_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [35:0] r_mag_q;
  logic [17:0] r_mag_d;
  logic [18:0] r_rem;
  logic [5:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_signed;
  logic [17:0] r_dvd_lo;
  logic        r_valid;
  logic [35:0] r_quotient;
  logic [17:0] r_remainder;
  logic        r_dbz;
  logic        r_ovf;

  logic        w_dvd_neg;
  logic        w_dvs_neg;
  logic [19:0] w_shift;
  logic [18:0] w_diff;
  logic        w_ge;
  logic [35:0] w_q_fix;
  logic [17:0] w_r_fix;
  logic        w_ovf_fix;

  assign w_dvd_neg = i_dividend_ns & i_dividend[35];
  assign w_dvs_neg = i_divisor_ns & i_divisor[17];

  // The dividend register doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign w_shift = {r_rem, r_mag_q[35]};
  assign w_ge    = (w_shift >= {2'b00, r_mag_d});
  assign w_diff  = w_shift[18:0] - {1'b0, r_mag_d};

  assign w_q_fix   = r_neg_q ? (36'd0 - r_mag_q) : r_mag_q;
  assign w_r_fix   = r_neg_r ? (18'd0 - r_rem[17:0]) : r_rem[17:0];
  assign w_ovf_fix = r_signed & (r_neg_q ? (r_mag_q > 36'h8_0000_0000) : r_mag_q[35]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_valid) w_next = S_CALC;
      S_CALC: if (r_cnt == 6'd35) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (r_valid && i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mag_q     <= '0;
      r_mag_d     <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_signed    <= 1'b0;
      r_dvd_lo    <= '0;
      r_valid     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (i_valid) begin
            r_mag_q  <= w_dvd_neg ? (36'd0 - i_dividend) : i_dividend;
            r_mag_d  <= w_dvs_neg ? (18'd0 - i_divisor) : i_divisor;
            r_neg_q  <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r  <= w_dvd_neg;
            r_signed <= i_dividend_ns | i_divisor_ns;
            r_dvd_lo <= i_dividend[17:0];
            r_rem    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_mag_q <= {r_mag_q[34:0], w_ge};
          r_rem   <= w_ge ? w_diff : w_shift[18:0];
          r_cnt   <= r_cnt + 6'd1;
        end
        S_FIX: begin
          if (r_mag_d == 18'd0) begin
            r_quotient  <= 36'hF_FFFF_FFFF;
            r_remainder <= r_dvd_lo;
            r_dbz       <= 1'b1;
            r_ovf       <= 1'b0;
          end else begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_dbz       <= 1'b0;
            r_ovf       <= w_ovf_fix;
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the result; it is withdrawn on the transfer edge.
          r_valid <= !(r_valid && i_ready);
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_valid     = r_valid;
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
  assign o_dbz       = r_dbz;
  assign o_ovf       = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div36x18.sv
// Bench for div36x18: arithmetic reference model with scoreboard, latency and handshake checks,
// plus literal expectations for the hand-worked cases.
module tb_div36x18;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [35:0] i_dividend;
  logic [17:0] i_divisor;
  logic        i_dividend_ns;
  logic        i_divisor_ns;
  logic        o_valid;
  logic        i_ready;
  logic [35:0] o_quotient;
  logic [17:0] o_remainder;
  logic        o_dbz;
  logic        o_ovf;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [55:0] exp_q[$];

  div36x18 dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .i_dividend_ns (i_dividend_ns),
    .i_divisor_ns  (i_divisor_ns),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_dbz         (o_dbz),
    .o_ovf         (o_ovf),
    .o_dbg_state   (o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer truncating division on the operands as interpreted by their flags.
  function automatic logic [55:0] model(input logic [35:0] dvd, input logic [17:0] dvs,
                                        input logic fa, input logic fb);
    longint a;
    longint b;
    longint q;
    longint r;
    logic [35:0] qq;
    logic [17:0] rr;
    logic ov;
    a = fa ? longint'($signed(dvd)) : longint'({28'd0, dvd});
    b = fb ? longint'($signed(dvs)) : longint'({46'd0, dvs});
    if (b == 0) return {36'hF_FFFF_FFFF, dvd[17:0], 1'b1, 1'b0};
    q  = a / b;
    r  = a % b;
    ov = (fa || fb) && ((q > 64'sd34359738367) || (q < -64'sd34359738368));
    qq = q[35:0];
    rr = r[17:0];
    return {qq, rr, 1'b0, ov};
  endfunction

  // scoreboard compare: every cycle the result is presented
  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", o_valid, 1'b0);
      else chk("scoreboard", {o_quotient, o_remainder, o_dbz, o_ovf}, exp_q[0]);
    end
  end

  always @(posedge i_clk) begin
    if (!i_rst && o_valid && i_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // driver: one full transaction, called and returning at a falling edge
  task automatic run_op(input logic [35:0] dvd, input logic [17:0] dvs, input logic fa,
                        input logic fb, input int hold, input logic probe,
                        input logic use_lit, input logic [55:0] lit, input string tag);
    int n;
    logic done;
    logic [55:0] e;
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_ready_idle"}, o_ready, 1'b1);
    e = model(dvd, dvs, fa, fb);
    exp_q.push_back(e);
    i_dividend    = dvd;
    i_divisor     = dvs;
    i_dividend_ns = fa;
    i_divisor_ns  = fb;
    i_valid       = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid    = 1'b0;
    i_dividend = {4'($urandom_range(15)), $urandom()};
    i_divisor  = 18'($urandom_range(262143));
    n = 0;
    done = 1'b0;
    while (!done && n < 80) begin
      @(posedge i_clk);
      n++;
      @(negedge i_clk);
      if (o_valid) done = 1'b1;
      else chk({tag, "_busy_ready"}, o_ready, 1'b0);
    end
    chk({tag, "_latency"}, n, 38);
    if (use_lit) chk({tag, "_literal"}, {o_quotient, o_remainder, o_dbz, o_ovf}, lit);
    repeat (hold) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk({tag, "_hold_valid"}, o_valid, 1'b1);
      chk({tag, "_hold_ready"}, o_ready, 1'b0);
    end
    i_ready = 1'b1;
    if (probe) begin
      i_dividend    = 36'd81;
      i_divisor     = 18'd9;
      i_dividend_ns = 1'b0;
      i_divisor_ns  = 1'b0;
      i_valid       = 1'b1;
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk({tag, "_taken_valid"}, o_valid, 1'b0);
    chk({tag, "_taken_ready"}, o_ready, 1'b1);
    chk({tag, "_idle_hold"}, {o_quotient, o_remainder, o_dbz, o_ovf}, e);
  endtask

  initial begin
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_dividend = '0;
    i_divisor = '0;
    i_dividend_ns = 1'b0;
    i_divisor_ns = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("reset_ready", o_ready, 1'b1);
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_result", {o_quotient, o_remainder, o_dbz, o_ovf}, 56'd0);

    run_op(36'd1000, 18'd7, 1'b0, 1'b0, 10, 1'b1, 1'b1, {36'd142, 18'd6, 2'b00}, "u1000_7");
    run_op(36'hF_FFFF_FF9C, 18'd7, 1'b1, 1'b1, 0, 1'b0, 1'b1,
           {36'hF_FFFF_FFF2, 18'h3_FFFE, 2'b00}, "sneg_pos");
    run_op(36'd100, 18'h3_FFF9, 1'b1, 1'b1, 2, 1'b0, 1'b1,
           {36'hF_FFFF_FFF2, 18'd2, 2'b00}, "spos_neg");
    run_op(36'hF_FFFF_FF9C, 18'h3_FFF9, 1'b1, 1'b1, 0, 1'b0, 1'b1,
           {36'd14, 18'h3_FFFE, 2'b00}, "sneg_neg");
    run_op(36'h0_0001_2345, 18'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1,
           {36'hF_FFFF_FFFF, 18'h1_2345, 2'b10}, "dbz");
    run_op(36'h8_0000_0000, 18'h3_FFFF, 1'b1, 1'b1, 0, 1'b0, 1'b1,
           {36'h8_0000_0000, 18'd0, 2'b01}, "ovf");

    run_op(36'hF_FFFF_FFFF, 18'd1, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0, "umax_1");
    run_op(36'hF_FFFF_FFFF, 18'h3_FFFF, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0, "umax_umax");
    run_op(36'hF_FFFF_FFFF, 18'h3_FFFF, 1'b0, 1'b1, 0, 1'b0, 1'b0, '0, "umax_sneg1");
    run_op(36'h8_0000_0000, 18'h2_0000, 1'b1, 1'b1, 0, 1'b0, 1'b0, '0, "smin_smin");
    run_op(36'hF_FFFF_FFFF, 18'd3, 1'b1, 1'b0, 0, 1'b0, 1'b0, '0, "sneg1_u3");
    run_op(36'd7, 18'd100, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0, "small");
    run_op(36'h0_0000_0000, 18'h3_FFF0, 1'b1, 1'b1, 0, 1'b0, 1'b0, '0, "zero_dvd");
    for (int k = 0; k < 4; k++) begin
      run_op({4'($urandom_range(15)), $urandom()}, 18'($urandom_range(262143)),
             1'($urandom_range(1)), 1'($urandom_range(1)), k, 1'b0, 1'b0, '0, "rand");
    end

    // abort an operation in its 20th CALC cycle
    i_dividend    = 36'd1000;
    i_divisor     = 18'd7;
    i_dividend_ns = 1'b0;
    i_divisor_ns  = 1'b0;
    i_valid       = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (19) @(posedge i_clk);
    @(negedge i_clk);
    chk("pre_abort_busy", o_ready, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("abort_ready", o_ready, 1'b1);
    chk("abort_valid", o_valid, 1'b0);
    chk("abort_result", {o_quotient, o_remainder, o_dbz, o_ovf}, 56'd0);
    run_op(36'd81, 18'd9, 1'b0, 1'b0, 0, 1'b0, 1'b1, {36'd9, 18'd0, 2'b00}, "post_abort");

    repeat (3) @(negedge i_clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
